// File: rtl/conv_cfg_pkg.sv
// Shared types for the conv_block weight loader.
// Loader states and the weight-store word count helper.
package conv_cfg_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      LOAD,
      RUN,
      DRAIN
   } ldr_state_t;

   function automatic int conv_words(
      input int out_dim,
      input int in_dim,
      input int k
   );
      return out_dim * (1 + in_dim * k * k);
   endfunction

endpackage

// File: rtl/conv_frame_gate.sv
// Frame-granular pixel gate in front of conv_block.
// Passes whole frames only while enabled; reports frame boundaries upstream.
module conv_frame_gate
   import conv_cfg_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_en,
   input  logic          en,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   input  logic          i_sop,
   input  logic          i_eop,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   output logic          o_sop,
   output logic          o_eop,
   output logic          frame_dropped,
   output logic          eop_passed,
   output logic          boundary
);

   logic          in_frame_q, in_frame_d;
   logic [DW-1:0] o_data_q, o_data_d;
   logic          o_valid_q, o_valid_d;
   logic          o_sop_q, o_sop_d;
   logic          o_eop_q, o_eop_d;
   logic          drop_q, drop_d;
   logic          pass;

   always_comb begin
      pass       = i_valid & en & (in_frame_q | i_sop);
      in_frame_d = in_frame_q;
      o_data_d   = o_data_q;
      o_valid_d  = o_valid_q;
      o_sop_d    = o_sop_q;
      o_eop_d    = o_eop_q;
      drop_d     = 1'b0;
      if (clk_en) begin
         o_valid_d = pass;
         o_sop_d   = pass & i_sop;
         o_eop_d   = pass & i_eop;
         drop_d    = i_valid & i_sop & ~pass;
         if (pass) begin
            o_data_d = i_data;
            // eop wins so a one-pixel frame leaves in_frame clear
            if (i_eop)
               in_frame_d = 1'b0;
            else if (i_sop)
               in_frame_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_frame_q <= 1'b0;
         o_data_q   <= '0;
         o_valid_q  <= 1'b0;
         o_sop_q    <= 1'b0;
         o_eop_q    <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         in_frame_q <= in_frame_d;
         o_data_q   <= o_data_d;
         o_valid_q  <= o_valid_d;
         o_sop_q    <= o_sop_d;
         o_eop_q    <= o_eop_d;
         drop_q     <= drop_d;
      end
   end

   assign eop_passed    = clk_en & pass & i_eop;
   assign boundary      = ~(i_valid & i_sop) & (~in_frame_q | eop_passed);
   assign o_data        = o_data_q;
   assign o_valid       = o_valid_q;
   assign o_sop         = o_sop_q;
   assign o_eop         = o_eop_q;
   assign frame_dropped = drop_q;

endmodule

// File: rtl/conv_weight_loader.sv
// Weight-store sequencer for one conv_block: streams kernel+bias words
// into the store and holds pixel frames off until the set is complete.
module conv_weight_loader
   import conv_cfg_pkg::*;
#(
   parameter int PIX_WIDTH        = 8,
   parameter int WEIGHT_WIDTH     = 10,
   parameter int KERNEL_DIMENSION = 3,
   parameter int IN_DIMENSION     = 1,
   parameter int OUT_DIMENSION    = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clk_en,
   input  logic                              cfg_start,
   input  logic [WEIGHT_WIDTH-1:0]           w_data,
   input  logic                              w_valid,
   output logic                              w_ready,
   output logic [31:0]                       mem_data,
   output logic [31:0]                       mem_addr,
   output logic                              mem_wr,
   input  logic [IN_DIMENSION*PIX_WIDTH-1:0] i_data,
   input  logic                              i_valid,
   input  logic                              i_sop,
   input  logic                              i_eop,
   output logic [IN_DIMENSION*PIX_WIDTH-1:0] o_data,
   output logic                              o_valid,
   output logic                              o_sop,
   output logic                              o_eop,
   output logic                              loaded,
   output logic                              frame_dropped
);

   localparam int WORDS =
      conv_words(OUT_DIMENSION, IN_DIMENSION, KERNEL_DIMENSION);
   localparam int CW = $clog2(WORDS);
   localparam int DW = IN_DIMENSION * PIX_WIDTH;

   ldr_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_wr_q, mem_wr_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_data_q, mem_data_d;
   logic          eop_passed;
   logic          boundary;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_wr_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      unique case (state_q)
         EMPTY: begin
            if (cfg_start)
               state_d = LOAD;
         end
         LOAD: begin
            if (w_valid) begin
               mem_wr_d   = 1'b1;
               mem_addr_d = {{(32-CW){1'b0}}, cnt_q};
               mem_data_d = {{(32-WEIGHT_WIDTH){w_data[WEIGHT_WIDTH-1]}},
                             w_data};
               if (cnt_q == CW'(WORDS-1)) begin
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RUN: begin
            // reload immediately only between frames, else finish the frame
            if (cfg_start)
               state_d = boundary ? LOAD : DRAIN;
         end
         DRAIN: begin
            if (eop_passed)
               state_d = LOAD;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         cnt_q      <= '0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_wr_q   <= mem_wr_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   assign w_ready  = (state_q == LOAD);
   assign loaded   = (state_q == RUN) | (state_q == DRAIN);
   assign mem_wr   = mem_wr_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;

   conv_frame_gate #(
      .DW(DW)
   ) u_gate (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .en           (loaded),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .i_sop        (i_sop),
      .i_eop        (i_eop),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_sop        (o_sop),
      .o_eop        (o_eop),
      .frame_dropped(frame_dropped),
      .eop_passed   (eop_passed),
      .boundary     (boundary)
   );

endmodule

// File: tb/tb_conv_weight_loader.sv
// Scoreboard bench for conv_weight_loader: frame-level pixel model
// and word-index weight model, checked by free-running monitors.
module tb_conv_weight_loader;

   localparam int PW    = 8;
   localparam int WW    = 10;
   localparam int WORDS = 40;
   localparam int DW    = PW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clk_en = 1'b1;
   logic          cfg_start = 1'b0;
   logic [WW-1:0] w_data = '0;
   logic          w_valid = 1'b0;
   logic          w_ready;
   logic [31:0]   mem_data;
   logic [31:0]   mem_addr;
   logic          mem_wr;
   logic [DW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          i_sop = 1'b0;
   logic          i_eop = 1'b0;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_sop;
   logic          o_eop;
   logic          loaded;
   logic          frame_dropped;

   conv_weight_loader dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .cfg_start(cfg_start),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .mem_data(mem_data), .mem_addr(mem_addr), .mem_wr(mem_wr),
      .i_data(i_data), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
      .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop),
      .loaded(loaded), .frame_dropped(frame_dropped)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wexp_t;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          sop;
      logic          eop;
   } pexp_t;

   wexp_t wq[$];
   pexp_t pq[$];
   wexp_t we;
   pexp_t pe;
   int    n_tests = 0;
   int    n_fail = 0;
   int    drop_cnt = 0;
   bit    upd = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sext(input logic [WW-1:0] v);
      return {{(32-WW){v[WW-1]}}, v};
   endfunction

   // weight-store writes, in order, with loaded rising on the final word
   always @(negedge clk) begin
      if (mem_wr) begin
         check("wq_nonempty", 32'(wq.size() != 0), 32'd1);
         if (wq.size() != 0) begin
            we = wq.pop_front();
            check("mem_addr", mem_addr, we.addr);
            check("mem_data", mem_data, we.data);
            check("loaded_at_wr", 32'(loaded),
                  32'(we.addr == 32'(WORDS-1)));
         end
      end
   end

   // output registers only move on edges where clk_en was high
   always @(posedge clk) upd <= clk_en;

   always @(negedge clk) begin
      if (upd && o_valid) begin
         check("pq_nonempty", 32'(pq.size() != 0), 32'd1);
         if (pq.size() != 0) begin
            pe = pq.pop_front();
            check("pix", {23'd0, o_data, o_sop, o_eop},
                  {23'd0, pe.d, pe.sop, pe.eop});
         end
      end
   end

   always @(negedge clk) if (frame_dropped) drop_cnt++;

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      i_sop   = 1'b0;
      i_eop   = 1'b0;
      clk_en  = 1'b1;
      repeat (n) tick();
   endtask

   // mode 0: word i = i except word 7 = 3FF; mode 1: random words
   task automatic load(input int n, input int mode);
      logic [WW-1:0] v;
      int b;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            w_valid = 1'b0;
            tick();
         end
         if (mode == 0)
            v = (i == 7) ? 10'h3FF : WW'(i);
         else
            v = WW'($urandom);
         w_valid = 1'b1;
         w_data  = v;
         b = 0;
         while (!w_ready && b < 50) begin
            tick();
            b++;
         end
         check("w_ready_in_load", 32'(w_ready), 32'd1);
         if (!w_ready) break;
         wq.push_back('{addr: 32'(i), data: sext(v)});
         tick();
      end
      w_valid = 1'b0;
      w_data  = '0;
   endtask

   task automatic send_frame(input int n, input bit exp_pass,
                             input int cfg_at, input int hold_at);
      logic [DW-1:0] d;
      bit consumed;
      bit cfg_done;
      int hold;
      cfg_done = 1'b0;
      for (int idx = 0; idx < n; idx++) begin
         d = DW'($urandom);
         consumed = 1'b0;
         hold = (idx == hold_at) ? 5 : 0;
         while (!consumed) begin
            i_valid = 1'b1;
            i_data  = d;
            i_sop   = (idx == 0);
            i_eop   = (idx == n - 1);
            if (hold > 0) begin
               clk_en = 1'b0;
               hold--;
            end else if (idx == cfg_at && !cfg_done) begin
               cfg_start = 1'b1;
               clk_en    = 1'b1;
               cfg_done  = 1'b1;
            end else begin
               clk_en = ($urandom_range(0, 7) != 0);
               if ($urandom_range(0, 9) == 0) i_valid = 1'b0;
            end
            consumed = clk_en && i_valid;
            if (consumed && exp_pass)
               pq.push_back('{d: d, sop: (idx == 0), eop: (idx == n - 1)});
            tick();
            cfg_start = 1'b0;
            if (consumed && exp_pass && idx == 0)
               check("sop_latency", {30'd0, o_valid, o_sop}, 32'd3);
         end
      end
      idle(0);
   endtask

   int d0;

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      check("rst_w_ready", 32'(w_ready), 32'd0);
      check("rst_loaded", 32'(loaded), 32'd0);
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_strobes", {29'd0, o_sop, o_eop, frame_dropped}, 32'd0);
      check("rst_o_data", 32'(o_data), 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_data", mem_data, 32'd0);
      rst = 1'b0;
      idle(2);

      // frame while empty is dropped
      d0 = drop_cnt;
      send_frame(12, 1'b0, -1, -1);
      idle(2);
      check("empty_drop_cnt", 32'(drop_cnt - d0), 32'd1);
      check("empty_w_ready", 32'(w_ready), 32'd0);
      check("empty_loaded", 32'(loaded), 32'd0);

      // first full load
      load(WORDS, 0);
      check("load_done_loaded", 32'(loaded), 32'd1);
      check("load_done_w_ready", 32'(w_ready), 32'd0);
      idle(2);

      // full 28x28 frame with a 5-cycle clk_en stall, plus short frames
      send_frame(784, 1'b1, -1, 300);
      idle(3);
      send_frame(1, 1'b1, -1, -1);
      idle(1);
      send_frame($urandom_range(5, 40), 1'b1, -1, 2);
      idle(2);
      check("run_loaded", 32'(loaded), 32'd1);

      // reload requested mid-frame: frame finishes, then LOAD
      send_frame(784, 1'b1, 99, -1);
      check("drain_to_load", 32'(w_ready), 32'd1);
      check("drain_loaded_low", 32'(loaded), 32'd0);
      d0 = drop_cnt;
      send_frame(20, 1'b0, -1, -1);
      idle(2);
      check("load_drop_cnt", 32'(drop_cnt - d0), 32'd1);
      load(WORDS, 1);
      idle(2);

      // reload on the eop cycle goes straight to LOAD
      send_frame(30, 1'b1, 29, -1);
      check("eop_cfg_load", 32'(w_ready), 32'd1);
      load(WORDS, 1);
      idle(2);

      // reload on the sop cycle drains that whole frame first
      send_frame(30, 1'b1, 0, -1);
      check("sop_cfg_load", 32'(w_ready), 32'd1);

      // reset in the middle of a load
      load(20, 1);
      idle(1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midload_rst_loaded", 32'(loaded), 32'd0);
      check("midload_rst_w_ready", 32'(w_ready), 32'd0);
      d0 = drop_cnt;
      send_frame(8, 1'b0, -1, -1);
      idle(2);
      check("post_rst_drop_cnt", 32'(drop_cnt - d0), 32'd1);
      load(WORDS, 1);
      check("reload_loaded", 32'(loaded), 32'd1);
      idle(2);
      send_frame(50, 1'b1, -1, 10);
      idle(4);

      check("wq_drained", 32'(wq.size()), 32'd0);
      check("pq_drained", 32'(pq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
